fetch_hazard_ctrl: RTL and testbench
====================================

# fetch_hazard_ctrl

Pipeline hazard and redirect sequencer for the fetch stage. Watches the decode and execute stage registers and drives the fetch stage's hold, rewind and clear controls. Also drives a bubble into the decode/execute register. Covers three cases: load-use hazards, multi-cycle multiply/divide waits with a watchdog, and taken branch / jal-jr redirects. Sits between the decode/execute pipeline registers and `fetch`.

## Interface
Parameters:
- `MD_TIMEOUT`, 64: max cycles waiting for `md_ready` before abort.
- `CNT_W`, 16: width of the saturating stall-cycle counter.

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `aclr`  in  1  asynchronous, active-low reset.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in decode.
- `id_uses_rs`, `id_uses_rt`  in  1 each  decode instruction reads that source.
- `ex_is_load`  in  1  execute-stage instruction is a load.
- `ex_rd`  in  5  execute-stage destination register.
- `ex_is_md`  in  1  execute-stage instruction is multiply/divide.
- `md_ready`  in  1  multiply/divide result valid (1-cycle pulse).
- `ex_br_taken`  in  1  execute resolved a taken branch.
- `ex_jal_jr`  in  1  execute is jal/jr.
- `br`, `jal_jr`  out  1 each  redirect selects to fetch.
- `jal_jrClr`  out  1  clears fetch output registers.
- `stallA`  out  1  fetch holds PC and issues a zero instruction.
- `stallB`  out  1  fetch rewinds PC by one.
- `dx_bubble`  out  1  load zero into the decode/execute register.
- `ex_hold`  out  1  execute stage holds its contents.
- `md_err`  out  1  one-cycle pulse on watchdog abort.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `stallA`=1.

## Operation
- States: RUN, MD_WAIT, REPLAY. Reset: RUN, watchdog=0, `stall_cnt`=0, all outputs 0.
- Hazard `lu` = `ex_is_load` & `ex_rd`≠0 & ((`id_uses_rs` & `id_rs`==`ex_rd`) | (`id_uses_rt` & `id_rt`==`ex_rd`)).
- Redirect `rd` = `ex_br_taken` | `ex_jal_jr`.
- RUN, priority rd > md > lu:
  - rd: `br`=`ex_br_taken`, `jal_jr`=`ex_jal_jr`, `jal_jrClr`=1, `dx_bubble`=1. Stay RUN.
  - `ex_is_md` & ~`md_ready`: `stallA`=1, `ex_hold`=1, `dx_bubble`=0. Clear watchdog, go to MD_WAIT.
  - `ex_is_md` & `md_ready` in the same cycle: no stall, stay RUN.
  - lu: `stallA`=1, `dx_bubble`=1 for exactly that cycle. Stay RUN. The stall resolves next cycle because the load has left execute.
- MD_WAIT: `stallA`=1, `ex_hold`=1, watchdog increments.
  - `md_ready`: go to RUN with no stall on that edge.
  - Watchdog reaches `MD_TIMEOUT`-1 without `md_ready`: pulse `md_err`, go to REPLAY.
  - `ex_br_taken`, `ex_jal_jr` and lu are ignored in MD_WAIT.
- REPLAY: exactly one cycle. `stallB`=1, `jal_jrClr`=1, `dx_bubble`=1, then RUN. This re-fetches the instruction following the aborted op.
- `stall_cnt` increments on every cycle with `stallA`=1 and saturates at all-ones.
- `br`, `jal_jr`, `jal_jrClr`, `stallA`, `stallB`, `dx_bubble` and `ex_hold` are combinational from state and inputs (Mealy). `md_err` and `stall_cnt` are registered.
- `stallA` and `stallB` are never both 1.

## Timing
- Hazard and redirect responses appear in the same cycle as the causing inputs: zero latency.
- Multiply/divide stall length is N+1 cycles of `stallA`, where `md_ready` arrives N cycles after MD_WAIT entry.
- Timeout path: `md_err` is high in the first REPLAY cycle. `stallB` is high in that same cycle.
- Reset mid-MD_WAIT or mid-REPLAY: asynchronous return to RUN, all outputs 0 immediately, counters 0.
- `aclr` deassertion takes effect at the next rising edge.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - state encoding (RUN=2'd0, MD_WAIT=2'd1, REPLAY=2'd2)
  - register-index width 5
  - opcode constants used by decode to derive `ex_is_load` and `ex_is_md`.
- One sub-module, `hazard_detect`, holds the purely combinational `lu` compare. It is reused by a future forwarding unit.
- The watchdog counter is `$clog2(MD_TIMEOUT)` bits wide.

## Test plan
- Load-use, case 1: `ex_is_load`=1, `ex_rd`=5, `id_rs`=5, `id_uses_rs`=1 → `stallA`=1 and `dx_bubble`=1 for one cycle, `stall_cnt`=1.
- Load-use, case 2: same stimulus with `ex_rd`=0 → no stall.
- Redirect: `ex_br_taken`=1 together with lu true → `br`=1, `jal_jrClr`=1, `dx_bubble`=1, `stallA`=0.
- Multiply/divide wait: `ex_is_md`=1, `md_ready` pulses 4 cycles after entry → `stallA`=1 and `ex_hold`=1 for 5 cycles, then RUN.
- Watchdog: `MD_TIMEOUT`=8, `md_ready` never arrives → `md_err` and `stallB` high on cycle 9, RUN on cycle 10.
- Reset and saturation:
  - `aclr`=0 mid-MD_WAIT → all outputs 0 asynchronously, state RUN.
  - `CNT_W`=4 with 20 stall cycles → `stall_cnt`=15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encoding, register-index width,
// decode opcode constants and the grouped fetch-control bundle.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MD_WAIT = 2'd1;
    localparam logic [1:0] ST_REPLAY  = 2'd2;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;

    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1a;
    localparam logic [5:0] FN_DIVU    = 6'h1b;

    typedef struct packed {
        logic br;
        logic jal_jr;
        logic clr;
        logic stall_a;
        logic stall_b;
        logic bubble;
        logic hold;
    } fetch_ctrl_t;

    // Used by decode to derive ex_is_load / ex_is_md from the instruction word.
    function automatic logic is_load_op(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_md_op(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_SPECIAL) && (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the decode sources and the
// execute-stage load destination; register 0 never creates a hazard.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    output logic             lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs && (id_rs == ex_rd);
    assign rt_hit = id_uses_rt && (id_rt == ex_rd);
    assign lu     = ex_is_load && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage hazard/redirect sequencer: load-use stalls, multiply/divide
// waits with a watchdog abort and replay, and branch / jal-jr redirects.
module fetch_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_md,
    input  logic             md_ready,
    input  logic             ex_br_taken,
    input  logic             ex_jal_jr,
    output logic             br,
    output logic             jal_jr,
    output logic             jal_jrClr,
    output logic             stallA,
    output logic             stallB,
    output logic             dx_bubble,
    output logic             ex_hold,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int              WD_W    = $clog2(MD_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

    logic [1:0]       state_reg, state_next;
    logic [WD_W-1:0]  wd_reg, wd_next;
    logic             md_err_reg, md_err_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    fetch_ctrl_t      ctl;
    logic             lu;
    logic             redirect;

    hazard_detect u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .lu         (lu)
    );

    assign redirect = ex_br_taken || ex_jal_jr;

    always_comb begin
        ctl         = '0;
        state_next  = state_reg;
        wd_next     = wd_reg;
        md_err_next = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (redirect) begin
                    ctl.br     = ex_br_taken;
                    ctl.jal_jr = ex_jal_jr;
                    ctl.clr    = 1'b1;
                    ctl.bubble = 1'b1;
                end else if (ex_is_md) begin
                    // A result already valid this cycle needs no wait at all.
                    if (!md_ready) begin
                        ctl.stall_a = 1'b1;
                        ctl.hold    = 1'b1;
                        state_next  = ST_MD_WAIT;
                        wd_next     = '0;
                    end
                end else if (lu) begin
                    ctl.stall_a = 1'b1;
                    ctl.bubble  = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                ctl.stall_a = 1'b1;
                ctl.hold    = 1'b1;
                if (md_ready) begin
                    state_next = ST_RUN;
                end else if (wd_reg == WD_LAST) begin
                    md_err_next = 1'b1;
                    state_next  = ST_REPLAY;
                end else begin
                    wd_next = wd_reg + WD_W'(1);
                end
            end
            ST_REPLAY: begin
                ctl.stall_b = 1'b1;
                ctl.clr     = 1'b1;
                ctl.bubble  = 1'b1;
                state_next  = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            state_reg     <= ST_RUN;
            wd_reg        <= '0;
            md_err_reg    <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            wd_reg     <= wd_next;
            md_err_reg <= md_err_next;
            if (ctl.stall_a && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    // Gated by reset so every control drops the instant aclr asserts,
    // regardless of what the pipeline registers are presenting.
    assign br        = ctl.br      && aclr;
    assign jal_jr    = ctl.jal_jr  && aclr;
    assign jal_jrClr = ctl.clr     && aclr;
    assign stallA    = ctl.stall_a && aclr;
    assign stallB    = ctl.stall_b && aclr;
    assign dx_bubble = ctl.bubble  && aclr;
    assign ex_hold   = ctl.hold    && aclr;
    assign md_err    = md_err_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed plus randomized bench for fetch_hazard_ctrl against a
// behavioural model built from the stall/redirect rules.
module tb_fetch_hazard_ctrl;

    localparam int T    = 8;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clock = 1'b0;
    logic          aclr  = 1'b0;
    logic [4:0]    id_rs, id_rt, ex_rd;
    logic          id_uses_rs, id_uses_rt, ex_is_load, ex_is_md, md_ready;
    logic          ex_br_taken, ex_jal_jr;
    logic          br, jal_jr, jal_jrClr, stallA, stallB, dx_bubble, ex_hold, md_err;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Model: waiting on a mul/div (with its age), replay pending, registered outputs.
    bit m_wait, m_replay, m_err;
    int m_age, m_cnt;

    fetch_hazard_ctrl #(.MD_TIMEOUT(T), .CNT_W(CW)) dut (
        .clock(clock), .aclr(aclr),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_is_md(ex_is_md), .md_ready(md_ready),
        .ex_br_taken(ex_br_taken), .ex_jal_jr(ex_jal_jr),
        .br(br), .jal_jr(jal_jr), .jal_jrClr(jal_jrClr), .stallA(stallA), .stallB(stallB),
        .dx_bubble(dx_bubble), .ex_hold(ex_hold), .md_err(md_err), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; ex_is_load = 0;
        ex_is_md = 0; md_ready = 0; ex_br_taken = 0; ex_jal_jr = 0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        ex_is_load = 1; ex_rd = r; id_rs = r; id_uses_rs = 1;
    endtask

    task automatic model_reset();
        m_wait = 0; m_replay = 0; m_err = 0; m_age = 0; m_cnt = 0;
    endtask

    // Expected {br, jal_jr, jal_jrClr, stallA, stallB, dx_bubble, ex_hold}.
    function automatic logic [6:0] exp_ctl();
        logic e_br, e_jal, e_clr, e_sa, e_sb, e_bub, e_hold, hz;
        e_br = 0; e_jal = 0; e_clr = 0; e_sa = 0; e_sb = 0; e_bub = 0; e_hold = 0;
        hz = ex_is_load && (ex_rd != 0) &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        if (!aclr) begin
        end else if (m_replay) begin
            e_sb = 1; e_clr = 1; e_bub = 1;
        end else if (m_wait) begin
            e_sa = 1; e_hold = 1;
        end else if (ex_br_taken || ex_jal_jr) begin
            e_br = ex_br_taken; e_jal = ex_jal_jr; e_clr = 1; e_bub = 1;
        end else if (ex_is_md) begin
            if (!md_ready) begin e_sa = 1; e_hold = 1; end
        end else if (hz) begin
            e_sa = 1; e_bub = 1;
        end
        return {e_br, e_jal, e_clr, e_sa, e_sb, e_bub, e_hold};
    endfunction

    task automatic model_edge();
        logic [6:0] e;
        if (!aclr) begin
            model_reset();
            return;
        end
        e = exp_ctl();
        m_err = m_wait && !md_ready && (m_age == T - 1);
        if (e[3] && m_cnt < CMAX) m_cnt++;
        if (m_replay) begin
            m_replay = 0;
        end else if (m_wait) begin
            if (md_ready) m_wait = 0;
            else if (m_age == T - 1) begin m_wait = 0; m_replay = 1; end
            else m_age++;
        end else if (!(ex_br_taken || ex_jal_jr) && ex_is_md && !md_ready) begin
            m_wait = 1; m_age = 0;
        end
    endtask

    task automatic settle(input string tag);
        logic [6:0] obs;
        #2;
        if (!aclr) model_reset();
        obs = {br, jal_jr, jal_jrClr, stallA, stallB, dx_bubble, ex_hold};
        $display("t=%0t %s ctl=%b err=%b cnt=%0d", $time, tag, obs, md_err, stall_cnt);
        check({tag, "_ctl"}, 32'(obs), 32'(exp_ctl()));
        check({tag, "_err"}, 32'(md_err), 32'(m_err));
        check({tag, "_cnt"}, 32'(stall_cnt), 32'(m_cnt));
        check({tag, "_ab"}, 32'(stallA && stallB), 32'(0));
    endtask

    task automatic edge_adv();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic tick(input string tag);
        settle(tag);
        edge_adv();
    endtask

    initial begin
        int sa_cnt;
        model_reset();
        set_idle();
        aclr = 0;
        @(negedge clock);
        settle("reset");
        aclr = 1;
        edge_adv();
        tick("idle");

        // Load-use on rs
        set_lu(5);
        settle("lu1");
        check("lu1_stallA", 32'(stallA), 32'(1));
        check("lu1_bubble", 32'(dx_bubble), 32'(1));
        edge_adv();
        set_idle();
        settle("lu1_after");
        check("lu1_cnt", 32'(stall_cnt), 32'(1));
        check("lu1_released", 32'(stallA), 32'(0));
        edge_adv();

        // Register 0 never hazards
        set_lu(0);
        settle("lu0");
        check("lu0_stallA", 32'(stallA), 32'(0));
        edge_adv();
        set_idle();

        // Redirect beats load-use
        set_lu(7);
        ex_br_taken = 1;
        settle("redir");
        check("redir_br", 32'(br), 32'(1));
        check("redir_clr", 32'(jal_jrClr), 32'(1));
        check("redir_stallA", 32'(stallA), 32'(0));
        edge_adv();
        set_idle();

        // Mul/div wait with ready in the fourth wait cycle
        ex_is_md = 1;
        sa_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            md_ready = (k == 4);
            settle($sformatf("md%0d", k));
            sa_cnt += int'(stallA && ex_hold);
            edge_adv();
        end
        set_idle();
        settle("md_done");
        check("md_stall_len", 32'(sa_cnt), 32'(5));
        check("md_run", 32'(ex_hold), 32'(0));
        edge_adv();

        // Watchdog abort: no md_ready; redirects ignored while waiting
        ex_is_md = 1;
        tick("wd0");
        for (int c = 1; c <= 8; c++) begin
            ex_br_taken = (c == 3);
            settle($sformatf("wd%0d", c));
            check($sformatf("wd%0d_err", c), 32'(md_err), 32'(0));
            check($sformatf("wd%0d_br", c), 32'(br), 32'(0));
            edge_adv();
        end
        ex_br_taken = 0;
        settle("wd9");
        check("wd9_err", 32'(md_err), 32'(1));
        check("wd9_stallB", 32'(stallB), 32'(1));
        edge_adv();
        set_idle();
        settle("wd10");
        check("wd10_stallB", 32'(stallB), 32'(0));
        check("wd10_err", 32'(md_err), 32'(0));
        edge_adv();

        // Asynchronous reset in the middle of a wait
        ex_is_md = 1;
        tick("ar0");
        settle("ar1");
        #1 aclr = 0;
        #1;
        model_reset();
        check("ar_outs", 32'({br, jal_jr, jal_jrClr, stallA, stallB, dx_bubble, ex_hold}), 32'(0));
        check("ar_cnt", 32'(stall_cnt), 32'(0));
        @(negedge clock);
        set_idle();
        set_lu(3);
        aclr = 1;
        settle("ar_run");
        check("ar_run_bubble", 32'(dx_bubble), 32'(1));
        check("ar_run_hold", 32'(ex_hold), 32'(0));
        edge_adv();

        // Counter saturation after 20 stall cycles
        for (int k = 0; k < 20; k++) tick("sat");
        set_idle();
        settle("sat_end");
        check("sat_cnt", 32'(stall_cnt), 32'(CMAX));
        edge_adv();

        // Randomized traffic, including occasional reset
        for (int n = 0; n < 400; n++) begin
            aclr        = ($urandom_range(0, 59) != 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_uses_rs  = 1'($urandom_range(0, 1));
            id_uses_rt  = 1'($urandom_range(0, 1));
            ex_is_load  = 1'($urandom_range(0, 1));
            ex_is_md    = ($urandom_range(0, 3) == 0);
            md_ready    = ($urandom_range(0, 5) == 0);
            ex_br_taken = ($urandom_range(0, 7) == 0);
            ex_jal_jr   = ($urandom_range(0, 7) == 0);
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
